// File: rtl/interrupt_scheduler_if.sv
// Interrupt presentation bus between the scheduler and the control unit.
// The scheduler (master) presents irq_valid/irq_code; the control unit
// (slave) answers with irq_ack and signals kernel_return when done.
interface interrupt_scheduler_if #(
  parameter int CODE_WIDTH = 2
);
  logic                  irq_valid;
  logic [CODE_WIDTH-1:0] irq_code;
  logic                  irq_ack;
  logic                  kernel_return;

  modport master (
    output irq_valid,
    output irq_code,
    input  irq_ack,
    input  kernel_return
  );

  modport slave (
    input  irq_valid,
    input  irq_code,
    output irq_ack,
    output kernel_return
  );
endinterface

// File: rtl/interrupt_scheduler.sv
// Preemption / interrupt sequencer. Owns the user time-slice counter and the
// two pending-interrupt latches (user syscall, quantum expiry), and presents
// one interrupt at a time to the control unit. The user request outranks
// quantum expiry. The quantum is frozen while kernel or I/O work runs.
// Optional feature: define INT_STATS_EN to add saturating per-code counters
// of accepted interrupts (user_irq_count, timer_irq_count).
module interrupt_scheduler #(
  parameter int QUANTUM_WIDTH   = 8,
  parameter int DEFAULT_QUANTUM = 128,
  parameter int CODE_WIDTH      = 2
`ifdef INT_STATS_EN
  ,
  parameter int STATS_WIDTH     = 16
`endif
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     is_Bios,
  input  logic                     is_kernel,
  input  logic                     is_input,
  input  logic                     is_output,
  input  logic                     user_request,
  input  logic                     quantum_we,
  input  logic [QUANTUM_WIDTH-1:0] quantum_value,
  interrupt_scheduler_if.master    irq_bus,
  output logic [QUANTUM_WIDTH-1:0] quantum_left,
  output logic [1:0]               sched_state
`ifdef INT_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0]   user_irq_count,
  output logic [STATS_WIDTH-1:0]   timer_irq_count
`endif
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    PENDING = 2'd2,
    SERVICE = 2'd3
  } state_t;

  localparam logic [CODE_WIDTH-1:0] CODE_NONE  = '0;
  localparam logic [CODE_WIDTH-1:0] CODE_USER  = CODE_WIDTH'(1);
  localparam logic [CODE_WIDTH-1:0] CODE_TIMER = CODE_WIDTH'(2);

  state_t                   state_q, state_d;
  logic [QUANTUM_WIDTH-1:0] quantum_reg_q, quantum_reg_d;
  logic [QUANTUM_WIDTH-1:0] quantum_left_q, quantum_left_d;
  logic                     user_pend_q, user_pend_d;
  logic                     timer_pend_q, timer_pend_d;
  logic [CODE_WIDTH-1:0]    code_q, code_d;
  logic                     served_timer_q, served_timer_d;
  logic                     frozen;
  logic                     user_first;
  logic                     any_pend;
`ifdef INT_STATS_EN
  logic [STATS_WIDTH-1:0]   user_cnt_q, user_cnt_d;
  logic [STATS_WIDTH-1:0]   timer_cnt_q, timer_cnt_d;
`endif

  // Next-state, quantum counting, pend latching and code selection.
  always_comb begin
    state_d        = state_q;
    quantum_reg_d  = quantum_reg_q;
    quantum_left_d = quantum_left_q;
    user_pend_d    = user_pend_q;
    timer_pend_d   = timer_pend_q;
    code_d         = code_q;
    served_timer_d = served_timer_q;
    frozen         = is_kernel | is_input | is_output;
    user_first     = user_pend_q | user_request;
    any_pend       = user_first | timer_pend_q;
`ifdef INT_STATS_EN
    user_cnt_d     = user_cnt_q;
    timer_cnt_d    = timer_cnt_q;
`endif

    if (quantum_we) begin
      quantum_reg_d = (quantum_value == '0) ? QUANTUM_WIDTH'(1) : quantum_value;
    end

    case (state_q)
      BOOT: begin
        if (!is_Bios) begin
          state_d        = RUN;
          quantum_left_d = quantum_reg_q;
        end
      end
      RUN: begin
        if (!frozen && quantum_left_q != '0) begin
          quantum_left_d = quantum_left_q - QUANTUM_WIDTH'(1);
          if (quantum_left_q == QUANTUM_WIDTH'(1)) begin
            timer_pend_d = 1'b1;
          end
        end
        if (any_pend) begin
          state_d = PENDING;
          code_d  = user_first ? CODE_USER : CODE_TIMER;
        end
      end
      PENDING: begin
        if (irq_bus.irq_ack) begin
          state_d = SERVICE;
          if (code_q == CODE_USER) begin
            user_pend_d    = 1'b0;
            served_timer_d = 1'b0;
`ifdef INT_STATS_EN
            if (user_cnt_q != '1) user_cnt_d = user_cnt_q + STATS_WIDTH'(1);
`endif
          end else begin
            timer_pend_d   = 1'b0;
            served_timer_d = 1'b1;
`ifdef INT_STATS_EN
            if (timer_cnt_q != '1) timer_cnt_d = timer_cnt_q + STATS_WIDTH'(1);
`endif
          end
        end
      end
      SERVICE: begin
        if (irq_bus.kernel_return) begin
          if (served_timer_q) begin
            quantum_left_d = quantum_reg_q;
          end
          if (any_pend) begin
            state_d = PENDING;
            code_d  = user_first ? CODE_USER : CODE_TIMER;
          end else begin
            state_d = RUN;
          end
        end
      end
      default: state_d = BOOT;
    endcase

    if (user_request && state_q != BOOT) begin
      user_pend_d = 1'b1;
    end
  end

  // State register with synchronous reset that overrides every input.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= BOOT;
      quantum_reg_q  <= QUANTUM_WIDTH'(DEFAULT_QUANTUM);
      quantum_left_q <= QUANTUM_WIDTH'(DEFAULT_QUANTUM);
      user_pend_q    <= 1'b0;
      timer_pend_q   <= 1'b0;
      code_q         <= CODE_NONE;
      served_timer_q <= 1'b0;
`ifdef INT_STATS_EN
      user_cnt_q     <= '0;
      timer_cnt_q    <= '0;
`endif
    end else begin
      state_q        <= state_d;
      quantum_reg_q  <= quantum_reg_d;
      quantum_left_q <= quantum_left_d;
      user_pend_q    <= user_pend_d;
      timer_pend_q   <= timer_pend_d;
      code_q         <= code_d;
      served_timer_q <= served_timer_d;
`ifdef INT_STATS_EN
      user_cnt_q     <= user_cnt_d;
      timer_cnt_q    <= timer_cnt_d;
`endif
    end
  end

  // The code is only visible while an interrupt is being presented.
  always_comb begin
    irq_bus.irq_valid = (state_q == PENDING);
    irq_bus.irq_code  = (state_q == PENDING) ? code_q : CODE_NONE;
    quantum_left      = quantum_left_q;
    sched_state       = state_q;
`ifdef INT_STATS_EN
    user_irq_count    = user_cnt_q;
    timer_irq_count   = timer_cnt_q;
`endif
  end

endmodule
